// File: rtl/ng_prm_pkg.sv
// Shared definitions for the read-bus arbiter: mode encodings, default sizes
// and the legacy channel numbering inherited from the original priority mux.
package ng_prm_pkg;

  localparam int PRM_N_DEF    = 11;
  localparam int PRM_W_DEF    = 16;
  localparam int PRM_PIPE_DEF = 1;
  localparam int PRM_CW_DEF   = 8;

  typedef enum logic [1:0] {
    PRM_STRICT = 2'b00,
    PRM_PRIO   = 2'b01,
    PRM_RR     = 2'b10
  } prm_mode_e;

  localparam logic [3:0] ZREG  = 4'd0;
  localparam logic [3:0] QREG  = 4'd1;
  localparam logic [3:0] LPREG = 4'd2;
  localparam logic [3:0] AREG  = 4'd3;
  localparam logic [3:0] INT   = 4'd4;
  localparam logic [3:0] CTR   = 4'd5;
  localparam logic [3:0] MBF   = 4'd6;
  localparam logic [3:0] ADR   = 4'd7;
  localparam logic [3:0] OUT   = 4'd8;
  localparam logic [3:0] INP   = 4'd9;

endpackage

// File: rtl/ng_prm_rr_pick.sv
// Combinational grant picker: strict one-hot, lowest-index priority, or
// round-robin search upward from a start pointer with wrap at N-1.
module ng_prm_rr_pick
  import ng_prm_pkg::*;
#(
  parameter int N = PRM_N_DEF
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   start,
  input  logic [1:0]   mode,
  output logic [3:0]   idx,
  output logic         vld
);

  logic [3:0] low_idx;
  logic       low_vld;
  logic [3:0] rr_idx;
  logic       rr_vld;
  logic       multi;

  assign multi = |(req & (req - N'(1)));

  always_comb begin
    low_idx = '0;
    low_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        low_idx = 4'(i);
        low_vld = 1'b1;
      end
    end
  end

  // Walk offsets from the top down so the smallest offset from start wins.
  always_comb begin
    int j;
    j      = 0;
    rr_idx = '0;
    rr_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        rr_idx = 4'(j);
        rr_vld = 1'b1;
      end
    end
  end

  always_comb begin
    idx = low_idx;
    vld = 1'b0;
    case (prm_mode_e'(mode))
      PRM_PRIO: vld = low_vld;
      PRM_RR: begin
        idx = rr_idx;
        vld = rr_vld;
      end
      default: vld = low_vld & ~multi;
    endcase
    if (!vld) idx = '0;
  end

endmodule

// File: rtl/ng_prm_arb.sv
// Read-bus arbiter: picks one source bus (or the default bus) onto the write
// bus, ORs in the constant mask, and tracks multi-enable conflicts.
module ng_prm_arb
  import ng_prm_pkg::*;
#(
  parameter int N    = PRM_N_DEF,
  parameter int W    = PRM_W_DEF,
  parameter int PIPE = PRM_PIPE_DEF,
  parameter int CW   = PRM_CW_DEF
) (
  input  logic             CLK1,
  input  logic             NPURST,
  input  logic [N-1:0]     EN_N,
  input  logic [N*W-1:0]   RD_BUS,
  input  logic [W-1:0]     DEF_BUS,
  input  logic [W-1:0]     OR_MASK,
  input  logic [1:0]       MODE,
  input  logic             CLR_STKY,
  output logic [W-1:0]     WRITE_OUT_BUS,
  output logic [3:0]       GRANT,
  output logic             GRANT_VLD,
  output logic             CONFLICT,
  output logic             CONFLICT_STKY,
  output logic [CW-1:0]    CONFLICT_CNT
);

  logic [N-1:0] req;
  logic         multi;
  logic [3:0]   rr_ptr;
  logic [3:0]   pick_idx;
  logic         pick_vld;
  logic [W-1:0] sel_data;
  logic [W-1:0] out_data;

  assign req   = ~EN_N;
  assign multi = |(req & (req - N'(1)));

  ng_prm_rr_pick #(.N(N)) u_pick (
    .req   (req),
    .start (rr_ptr),
    .mode  (MODE),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  always_comb begin
    sel_data = DEF_BUS;
    for (int i = 0; i < N; i++) begin
      if (pick_vld && pick_idx == 4'(i)) sel_data = RD_BUS[i*W +: W];
    end
  end

  assign out_data = sel_data | OR_MASK;

  always_ff @(posedge CLK1 or negedge NPURST) begin
    if (!NPURST) begin
      rr_ptr <= '0;
    end else if (MODE == PRM_RR && pick_vld) begin
      rr_ptr <= (pick_idx == 4'(N - 1)) ? 4'd0 : pick_idx + 4'd1;
    end
  end

  // A clear on the same edge as a conflict discards that conflict.
  always_ff @(posedge CLK1 or negedge NPURST) begin
    if (!NPURST) begin
      CONFLICT      <= 1'b0;
      CONFLICT_STKY <= 1'b0;
      CONFLICT_CNT  <= '0;
    end else begin
      CONFLICT <= multi;
      if (CLR_STKY) begin
        CONFLICT_STKY <= 1'b0;
        CONFLICT_CNT  <= '0;
      end else if (multi) begin
        CONFLICT_STKY <= 1'b1;
        if (CONFLICT_CNT != '1) CONFLICT_CNT <= CONFLICT_CNT + CW'(1);
      end
    end
  end

  generate
    if (PIPE != 0) begin : g_pipe
      always_ff @(posedge CLK1 or negedge NPURST) begin
        if (!NPURST) begin
          WRITE_OUT_BUS <= '0;
          GRANT         <= '0;
          GRANT_VLD     <= 1'b0;
        end else begin
          WRITE_OUT_BUS <= out_data;
          GRANT         <= pick_idx;
          GRANT_VLD     <= pick_vld;
        end
      end
    end else begin : g_comb
      assign WRITE_OUT_BUS = out_data;
      assign GRANT         = pick_idx;
      assign GRANT_VLD     = pick_vld;
    end
  endgenerate

endmodule

// File: tb/tb_ng_prm_arb.sv
// Bench for ng_prm_arb: a registered and a combinational instance share inputs;
// directed vector table, saturation/clear sequence, random run against a model.
module tb_ng_prm_arb;
  localparam int N  = 11;
  localparam int W  = 16;
  localparam int CW = 8;

  logic           CLK1 = 1'b0;
  logic           NPURST = 1'b0;
  logic [N-1:0]   EN_N = '1;
  logic [W-1:0]   ch [N];
  logic [N*W-1:0] RD_BUS;
  logic [W-1:0]   DEF_BUS = '0;
  logic [W-1:0]   OR_MASK = '0;
  logic [1:0]     MODE = 2'b00;
  logic           CLR_STKY = 1'b0;

  logic [W-1:0]  p1_out, p0_out;
  logic [3:0]    p1_gnt, p0_gnt;
  logic          p1_vld, p0_vld, p1_conf, p0_conf, p1_stky, p0_stky;
  logic [CW-1:0] p1_cnt, p0_cnt;

  int total = 0;
  int bad = 0;

  int         m_ptr;
  bit         m_conf, m_stky;
  int         m_cnt;
  logic [W-1:0] m_out;
  int         m_gnt;
  bit         m_vld;

  typedef struct {
    logic [N-1:0] en_n;
    logic [1:0]   mode;
    logic [W-1:0] mask;
    logic [W-1:0] out;
    int           gnt;
    bit           vld;
    bit           conf;
    bit           stky;
    int           cnt;
    int           ptr;
  } vec_t;

  vec_t tv[14];

  always #5 CLK1 = ~CLK1;

  always_comb begin
    RD_BUS = '0;
    for (int i = 0; i < N; i++) RD_BUS[i*W +: W] = ch[i];
  end

  ng_prm_arb #(.N(N), .W(W), .PIPE(1), .CW(CW)) u_p1 (
    .CLK1(CLK1), .NPURST(NPURST), .EN_N(EN_N), .RD_BUS(RD_BUS), .DEF_BUS(DEF_BUS),
    .OR_MASK(OR_MASK), .MODE(MODE), .CLR_STKY(CLR_STKY), .WRITE_OUT_BUS(p1_out),
    .GRANT(p1_gnt), .GRANT_VLD(p1_vld), .CONFLICT(p1_conf), .CONFLICT_STKY(p1_stky),
    .CONFLICT_CNT(p1_cnt));

  ng_prm_arb #(.N(N), .W(W), .PIPE(0), .CW(CW)) u_p0 (
    .CLK1(CLK1), .NPURST(NPURST), .EN_N(EN_N), .RD_BUS(RD_BUS), .DEF_BUS(DEF_BUS),
    .OR_MASK(OR_MASK), .MODE(MODE), .CLR_STKY(CLR_STKY), .WRITE_OUT_BUS(p0_out),
    .GRANT(p0_gnt), .GRANT_VLD(p0_vld), .CONFLICT(p0_conf), .CONFLICT_STKY(p0_stky),
    .CONFLICT_CNT(p0_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] en_of(input int bits);
    return ~N'(bits);
  endfunction

  // Reference selection from the list of requesting channel numbers.
  function automatic void ref_pick(input logic [N-1:0] en_v, input logic [1:0] md,
                                   input int ptr, output bit vld, output int idx);
    int q[$];
    bit found;
    for (int i = 0; i < N; i++) if (!en_v[i]) q.push_back(i);
    vld = 0;
    idx = 0;
    if (q.size() == 0) return;
    if (md == 2'b01) begin
      vld = 1; idx = q[0];
    end else if (md == 2'b10) begin
      vld = 1; idx = q[0]; found = 0;
      for (int k = 0; k < q.size(); k++)
        if (!found && q[k] >= ptr) begin idx = q[k]; found = 1; end
    end else if (q.size() == 1) begin
      vld = 1; idx = q[0];
    end
  endfunction

  task automatic model_comb(output logic [W-1:0] o, output int g, output bit v);
    ref_pick(EN_N, MODE, m_ptr, v, g);
    o = (v ? ch[g] : DEF_BUS) | OR_MASK;
  endtask

  task automatic model_edge();
    bit c;
    model_comb(m_out, m_gnt, m_vld);
    if (MODE == 2'b10 && m_vld) m_ptr = (m_gnt + 1) % N;
    c = ($countones(~EN_N) > 1);
    m_conf = c;
    if (CLR_STKY) begin
      m_stky = 0; m_cnt = 0;
    end else if (c) begin
      m_stky = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_conf = 0; m_stky = 0; m_cnt = 0; m_out = '0; m_gnt = 0; m_vld = 0;
  endtask

  task automatic adv();
    @(posedge CLK1);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs();
    EN_N = (N'($urandom_range(0, 3) == 0 ? $urandom : '1)) | N'($urandom) | N'($urandom);
    MODE = 2'($urandom_range(0, 3));
    for (int i = 0; i < N; i++) ch[i] = W'($urandom);
    DEF_BUS = W'($urandom);
    OR_MASK = W'($urandom) & W'($urandom) & W'($urandom);
    CLR_STKY = ($urandom_range(0, 15) == 0);
  endtask

  task automatic model_tick();
    logic [W-1:0] eo;
    int eg;
    bit ev;
    #2;
    model_comb(eo, eg, ev);
    chk("p0_out", p0_out, eo);
    chk("p0_gnt", p0_gnt, eg);
    chk("p0_vld", p0_vld, ev);
    adv();
    chk("p1_out", p1_out, m_out);
    chk("p1_gnt", p1_gnt, m_gnt);
    chk("p1_vld", p1_vld, m_vld);
    chk("conf", p1_conf, m_conf);
    chk("stky", p1_stky, m_stky);
    chk("cnt", p1_cnt, m_cnt);
    chk("p0_cnt", p0_cnt, m_cnt);
    chk("ptr", u_p1.rr_ptr, m_ptr);
  endtask

  initial begin
    tv[0]  = '{en_of(0),                   2'b00, 16'h0000, 16'h14E5, 0,  1'b0, 1'b0, 1'b0, 0, 0};
    tv[1]  = '{en_of(1<<3),                2'b00, 16'h0001, 16'h01FF, 3,  1'b1, 1'b0, 1'b0, 0, 0};
    tv[2]  = '{en_of((1<<3)|(1<<5)),       2'b00, 16'h0001, 16'h14E5, 0,  1'b0, 1'b1, 1'b1, 1, 0};
    tv[3]  = '{en_of((1<<2)|(1<<6)|(1<<9)),2'b01, 16'h0000, 16'h25A0, 2,  1'b1, 1'b1, 1'b1, 2, 0};
    tv[4]  = '{en_of(0),                   2'b01, 16'h0000, 16'h14E5, 0,  1'b0, 1'b0, 1'b1, 2, 0};
    tv[5]  = '{en_of(1<<9),                2'b11, 16'h0000, 16'h95A0, 9,  1'b1, 1'b0, 1'b1, 2, 0};
    tv[6]  = '{en_of((1<<1)|(1<<2)),       2'b11, 16'h8000, 16'h94E5, 0,  1'b0, 1'b1, 1'b1, 3, 0};
    tv[7]  = '{en_of((1<<0)|(1<<4)|(1<<10)),2'b10,16'h0000, 16'h05A0, 0,  1'b1, 1'b1, 1'b1, 4, 1};
    tv[8]  = '{en_of((1<<0)|(1<<4)|(1<<10)),2'b10,16'h0000, 16'h45A0, 4,  1'b1, 1'b1, 1'b1, 5, 5};
    tv[9]  = '{en_of((1<<0)|(1<<4)|(1<<10)),2'b10,16'h0000, 16'hA5A0, 10, 1'b1, 1'b1, 1'b1, 6, 0};
    tv[10] = '{en_of((1<<0)|(1<<4)|(1<<10)),2'b10,16'h0000, 16'h05A0, 0,  1'b1, 1'b1, 1'b1, 7, 1};
    tv[11] = '{en_of(1<<4),                2'b10, 16'h0000, 16'h45A0, 4,  1'b1, 1'b0, 1'b1, 7, 5};
    tv[12] = '{en_of(1<<4),                2'b10, 16'h0000, 16'h45A0, 4,  1'b1, 1'b0, 1'b1, 7, 5};
    tv[13] = '{en_of(1<<7),                2'b00, 16'h0000, 16'h0400, 7,  1'b1, 1'b0, 1'b1, 7, 5};

    model_reset();
    rand_inputs();
    CLR_STKY = 1'b0;
    repeat (2) @(posedge CLK1);
    #2;
    chk("rst_out", p1_out, 0);
    chk("rst_gnt", p1_gnt, 0);
    chk("rst_vld", p1_vld, 0);
    chk("rst_conf", p1_conf, 0);
    chk("rst_stky", p1_stky, 0);
    chk("rst_cnt", p1_cnt, 0);
    chk("rst_p0_cnt", p0_cnt, 0);
    chk("rst_ptr", u_p1.rr_ptr, 0);

    for (int i = 0; i < N; i++) ch[i] = {4'(i), 12'h5A0};
    ch[3] = 16'o000777;
    ch[7] = 16'o002000;
    DEF_BUS = 16'o012345;
    CLR_STKY = 1'b0;
    EN_N = '1;
    OR_MASK = '0;
    MODE = 2'b00;
    @(posedge CLK1);
    #1;
    NPURST = 1'b1;

    for (int v = 0; v < 14; v++) begin
      EN_N = tv[v].en_n;
      MODE = tv[v].mode;
      OR_MASK = tv[v].mask;
      #2;
      chk($sformatf("v%0d_p0_out", v), p0_out, tv[v].out);
      chk($sformatf("v%0d_p0_gnt", v), p0_gnt, tv[v].gnt);
      chk($sformatf("v%0d_p0_vld", v), p0_vld, tv[v].vld);
      adv();
      chk($sformatf("v%0d_p1_out", v), p1_out, tv[v].out);
      chk($sformatf("v%0d_p1_gnt", v), p1_gnt, tv[v].gnt);
      chk($sformatf("v%0d_p1_vld", v), p1_vld, tv[v].vld);
      chk($sformatf("v%0d_conf", v), p1_conf, tv[v].conf);
      chk($sformatf("v%0d_stky", v), p1_stky, tv[v].stky);
      chk($sformatf("v%0d_cnt", v), p1_cnt, tv[v].cnt);
      chk($sformatf("v%0d_ptr", v), u_p1.rr_ptr, tv[v].ptr);
    end

    // Saturation and clear-wins sequence under a steady conflict.
    MODE = 2'b01;
    EN_N = en_of((1<<1)|(1<<2));
    CLR_STKY = 1'b1;
    adv();
    chk("sat_clr0_cnt", p1_cnt, 0);
    chk("sat_clr0_stky", p1_stky, 0);
    CLR_STKY = 1'b0;
    repeat (254) adv();
    chk("sat_254", p1_cnt, 254);
    adv();
    chk("sat_255", p1_cnt, 255);
    repeat (45) adv();
    chk("sat_hold", p1_cnt, 255);
    chk("sat_hold_p0", p0_cnt, 255);
    chk("sat_stky", p1_stky, 1);
    CLR_STKY = 1'b1;
    adv();
    chk("clr_cnt", p1_cnt, 0);
    chk("clr_stky", p1_stky, 0);
    chk("clr_conf", p1_conf, 1);
    CLR_STKY = 1'b0;
    adv();
    chk("resume_cnt", p1_cnt, 1);
    chk("resume_stky", p1_stky, 1);

    for (int t = 0; t < 500; t++) begin
      rand_inputs();
      model_tick();
    end

    // Asynchronous reset between edges after a round-robin conflict.
    MODE = 2'b10;
    EN_N = en_of((1<<5)|(1<<8));
    CLR_STKY = 1'b0;
    model_tick();
    #2;
    NPURST = 1'b0;
    #1;
    chk("arst_cnt", p1_cnt, 0);
    chk("arst_p0_cnt", p0_cnt, 0);
    chk("arst_stky", p1_stky, 0);
    chk("arst_ptr", u_p1.rr_ptr, 0);
    chk("arst_p0_ptr", u_p0.rr_ptr, 0);
    chk("arst_out", p1_out, 0);
    @(posedge CLK1);
    #1;
    NPURST = 1'b1;
    model_reset();
    for (int t = 0; t < 60; t++) begin
      rand_inputs();
      model_tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
